// File: rtl/morse_pkg.sv
// Shared definitions for the Morse playback slice: phase encoding,
// phase lengths in Morse units and the letter width.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2,
        LGAP = 2'd3
    } morse_state_t;

    localparam logic [1:0] DOT_UNITS  = 2'd1;
    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] EGAP_UNITS = 2'd1;
    localparam logic [1:0] LGAP_UNITS = 2'd3;

    localparam int MAX_LEN = 5;

    // Oversized element counts play as a full-length letter.
    function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
        if (int'(len) > max_len) begin
            return 3'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Letter request / playback status bundle between the letter source and
// the Morse sequencer. The speed field only exists when MORSE_SPEED_EN
// is defined.
interface morse_sequencer_if #(
    parameter int MAX_LEN = 5
);
    logic               start;
    logic [MAX_LEN-1:0] pattern;
    logic [2:0]         len;
`ifdef MORSE_SPEED_EN
    logic [1:0]         speed;
`endif
    logic               audio_enable;
    logic               short;
    logic               long;
    logic               busy;
    logic               done;

`ifdef MORSE_SPEED_EN
    modport master (
        output start, pattern, len, speed,
        input  audio_enable, short, long, busy, done
    );

    modport slave (
        input  start, pattern, len, speed,
        output audio_enable, short, long, busy, done
    );
`else
    modport master (
        output start, pattern, len,
        input  audio_enable, short, long, busy, done
    );

    modport slave (
        input  start, pattern, len,
        output audio_enable, short, long, busy, done
    );
`endif

endinterface

// File: rtl/morse_tick_gen.sv
// Unit prescaler: emits a one-cycle unit_tick every 'period' cycles,
// restarting from zero whenever clear is asserted.
module morse_tick_gen #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [PW-1:0] period,
    output logic          unit_tick
);

    logic [PW-1:0] cnt_q;

    assign unit_tick = (cnt_q == period - 1'b1);

    // Count 0..period-1, wrapping on the tick and restarting on clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (unit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Morse letter playback: plays one latched letter as timed dot/dash tones
// followed by a trailing letter gap, then pulses done. Optional build
// macro MORSE_SPEED_EN adds a latched speed field that shortens the unit.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_LEN     = morse_pkg::MAX_LEN
) (
    input  logic             clk,
    input  logic             reset,
    morse_sequencer_if.slave bus
);

    localparam int PW   = $clog2(UNIT_CYCLES + 1);
    localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] UNIT_PERIOD = PW'(UNIT_CYCLES);

    morse_pkg::morse_state_t state_q;
    morse_pkg::morse_state_t state_d;

    logic [MAX_LEN-1:0] pattern_q;
    logic [IDXW-1:0]    idx_q;
    logic [1:0]         dur_q;
    logic               done_q;
    logic [2:0]         len_c;
    logic [PW-1:0]      period;
    logic [1:0]         phase_units;
    logic               unit_tick;
    logic               phase_end;
    logic               accept;
    logic               state_change;
    logic               tick_clear;
    logic               cur_bit;

    assign len_c        = morse_pkg::clamp_len(bus.len, MAX_LEN);
    assign accept       = (state_q == morse_pkg::IDLE) && bus.start;
    assign state_change = (state_d != state_q);
    assign tick_clear   = state_change || (state_q == morse_pkg::IDLE);
    assign cur_bit      = pattern_q[idx_q];
    assign phase_end    = unit_tick && (dur_q == phase_units - 2'd1);

`ifdef MORSE_SPEED_EN
    logic [1:0]    speed_q;
    logic [PW-1:0] shifted_period;

    // Speed is captured with the letter so mid-letter changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q <= '0;
        end else if (accept) begin
            speed_q <= bus.speed;
        end
    end

    // Faster speeds shorten the unit, never below one cycle.
    always_comb begin
        shifted_period = UNIT_PERIOD >> speed_q;
        period         = (shifted_period == '0) ? PW'(1) : shifted_period;
    end
`else
    assign period = UNIT_PERIOD;
`endif

    morse_tick_gen #(
        .PW(PW)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (tick_clear),
        .period   (period),
        .unit_tick(unit_tick)
    );

    // Length of the current phase in Morse units.
    always_comb begin
        phase_units = morse_pkg::DOT_UNITS;
        case (state_q)
            morse_pkg::TONE: phase_units = cur_bit ? morse_pkg::DASH_UNITS : morse_pkg::DOT_UNITS;
            morse_pkg::GAP:  phase_units = morse_pkg::EGAP_UNITS;
            morse_pkg::LGAP: phase_units = morse_pkg::LGAP_UNITS;
            default:         phase_units = morse_pkg::DOT_UNITS;
        endcase
    end

    // Phase sequencing; the last tone runs straight into the letter gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            morse_pkg::IDLE: begin
                if (bus.start) begin
                    state_d = (len_c == 3'd0) ? morse_pkg::LGAP : morse_pkg::TONE;
                end
            end
            morse_pkg::TONE: begin
                if (phase_end) begin
                    state_d = (idx_q == '0) ? morse_pkg::LGAP : morse_pkg::GAP;
                end
            end
            morse_pkg::GAP: begin
                if (phase_end) begin
                    state_d = morse_pkg::TONE;
                end
            end
            morse_pkg::LGAP: begin
                if (phase_end) begin
                    state_d = morse_pkg::IDLE;
                end
            end
            default: state_d = morse_pkg::IDLE;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= morse_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Units elapsed in the current phase, restarted on every phase change.
    always_ff @(posedge clk) begin
        if (reset || tick_clear) begin
            dur_q <= '0;
        end else if (unit_tick) begin
            dur_q <= dur_q + 2'd1;
        end
    end

    // Letter capture on accept and element stepping after each gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
            idx_q     <= '0;
        end else if (accept) begin
            pattern_q <= bus.pattern;
            idx_q     <= (len_c == 3'd0) ? '0 : IDXW'(len_c - 3'd1);
        end else if ((state_q == morse_pkg::GAP) && phase_end) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    // Done fires in the first IDLE cycle after the letter gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == morse_pkg::LGAP) && phase_end;
        end
    end

    assign bus.audio_enable = (state_q == morse_pkg::TONE);
    assign bus.long         = (state_q == morse_pkg::TONE) && cur_bit;
    assign bus.short        = (state_q == morse_pkg::TONE) && !cur_bit;
    assign bus.busy         = (state_q != morse_pkg::IDLE);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: every letter request pushes its
// expected per-cycle waveform {audio_enable, short, long, busy, done};
// a negedge monitor pops and compares one entry per cycle.
module tb_morse_sequencer;

    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;

    logic [4:0] q4[$];
    logic [4:0] q1[$];
    logic [4:0] act4;
    logic [4:0] act1;
    logic [4:0] exp4;
    logic [4:0] exp1;

    always #5 clk = ~clk;

    morse_sequencer_if bus4 ();
    morse_sequencer_if bus1 ();

    morse_sequencer #(.UNIT_CYCLES(4)) u4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    morse_sequencer #(.UNIT_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    assign act4 = {bus4.audio_enable, bus4.short, bus4.long, bus4.busy, bus4.done};
    assign act1 = {bus1.audio_enable, bus1.short, bus1.long, bus1.busy, bus1.done};

`ifdef MORSE_SPEED_EN
    logic [4:0] q8[$];
    logic [4:0] act8;
    logic [4:0] exp8;

    morse_sequencer_if bus8 ();
    morse_sequencer #(.UNIT_CYCLES(8)) u8 (.clk(clk), .reset(reset), .bus(bus8.slave));

    assign act8 = {bus8.audio_enable, bus8.short, bus8.long, bus8.busy, bus8.done};
`endif

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
        end
    endtask

    function automatic int qSize(input int inst);
        case (inst)
            0: return q4.size();
            1: return q1.size();
`ifdef MORSE_SPEED_EN
            2: return q8.size();
`endif
            default: return 0;
        endcase
    endfunction

    task automatic pushExp(input int inst, input logic [4:0] val);
        case (inst)
            0: q4.push_back(val);
            1: q1.push_back(val);
`ifdef MORSE_SPEED_EN
            2: q8.push_back(val);
`endif
            default: ;
        endcase
    endtask

    function automatic int unitFor(input int inst, input logic [1:0] spd);
        int u;
        case (inst)
            0: u = 4;
            1: u = 1;
            default: u = 8 >> spd;
        endcase
        return (u < 1) ? 1 : u;
    endfunction

    task automatic driveInputs(input int inst, input logic s, input logic [4:0] pat,
                               input logic [2:0] len, input logic [1:0] spd);
        case (inst)
            0: begin
                bus4.start = s; bus4.pattern = pat; bus4.len = len;
`ifdef MORSE_SPEED_EN
                bus4.speed = 2'd0;
`endif
            end
            1: begin
                bus1.start = s; bus1.pattern = pat; bus1.len = len;
`ifdef MORSE_SPEED_EN
                bus1.speed = 2'd0;
`endif
            end
            default: begin
`ifdef MORSE_SPEED_EN
                bus8.start = s; bus8.pattern = pat; bus8.len = len; bus8.speed = spd;
`endif
            end
        endcase
    endtask

    // Reference waveform for cycles 1..done of one letter; limit < 0 keeps
    // the whole letter, otherwise only the first 'limit' cycles.
    task automatic pushLetter(input int inst, input logic [4:0] pat, input logic [2:0] len,
                              input int unit, input int limit, input int tail);
        logic [4:0] w[$];
        int l;
        int tu;
        l = (int'(len) > 5) ? 5 : int'(len);
        for (int e = l - 1; e >= 0; e--) begin
            tu = pat[e] ? 3 * unit : unit;
            repeat (tu) w.push_back(pat[e] ? 5'b10110 : 5'b11010);
            if (e != 0) repeat (unit) w.push_back(5'b00010);
        end
        repeat (3 * unit) w.push_back(5'b00010);
        w.push_back(5'b00001);
        if (limit >= 0) begin
            while (w.size() > limit) w.delete(w.size() - 1);
        end
        repeat (tail) w.push_back(5'b00000);
        foreach (w[i]) pushExp(inst, w[i]);
    endtask

    // Issue one start strobe (called just after a rising edge). Waits until
    // only the current cycle's expectation is pending, so a letter can be
    // launched on the done cycle of the previous one.
    task automatic applyStimulus(input int inst, input logic [4:0] pat, input logic [2:0] len,
                                 input logic [1:0] spd, input int limit, input int tail);
        int n;
        n = 0;
        while (qSize(inst) > 1 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (qSize(inst) > 1) checkOutput("start_wait_timeout", qSize(inst), 1);
        if (qSize(inst) == 0) pushExp(inst, 5'b00000);
        driveInputs(inst, 1'b1, pat, len, spd);
        pushLetter(inst, pat, len, unitFor(inst, spd), limit, tail);
        @(posedge clk); #1;
        driveInputs(inst, 1'b0, 5'($urandom), 3'($urandom), 2'($urandom));
    endtask

    task automatic waitDrain(input int inst);
        int n;
        n = 0;
        while (qSize(inst) > 0 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", qSize(inst), 0);
    endtask

    // Per-cycle scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            exp4 = q4.pop_front();
            checkOutput("u4_outputs", 32'(act4), 32'(exp4));
        end
        if (q1.size() > 0) begin
            exp1 = q1.pop_front();
            checkOutput("u1_outputs", 32'(act1), 32'(exp1));
        end
`ifdef MORSE_SPEED_EN
        if (q8.size() > 0) begin
            exp8 = q8.pop_front();
            checkOutput("u8_outputs", 32'(act8), 32'(exp8));
        end
`endif
    end

    initial begin
        driveInputs(0, 1'b0, 5'd0, 3'd0, 2'd0);
        driveInputs(1, 1'b0, 5'd0, 3'd0, 2'd0);
        driveInputs(2, 1'b0, 5'd0, 3'd0, 2'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_u4", 32'(act4), 32'd0);
        checkOutput("reset_u1", 32'(act1), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Letter 'A' with a start pulse at cycle 6 that must be ignored,
        // then a letter launched on the done cycle.
        applyStimulus(0, 5'b00001, 3'd2, 2'd0, -1, 0);
        repeat (5) @(posedge clk);
        #1;
        driveInputs(0, 1'b1, 5'b10101, 3'd5, 2'd0);
        @(posedge clk); #1;
        driveInputs(0, 1'b0, 5'd0, 3'd0, 2'd0);
        applyStimulus(0, 5'b00000, 3'd1, 2'd0, -1, 3);
        waitDrain(0);

        // Empty letter: only the trailing gap.
        applyStimulus(0, 5'b11111, 3'd0, 2'd0, -1, 3);
        waitDrain(0);

        // Clamped length at one cycle per unit, alongside a mixed letter.
        applyStimulus(1, 5'b11111, 3'd7, 2'd0, -1, 3);
        applyStimulus(0, 5'b10110, 3'd5, 2'd0, -1, 2);
        waitDrain(1);
        waitDrain(0);
        applyStimulus(1, 5'b00101, 3'd3, 2'd0, -1, 2);
        waitDrain(1);

        // Reset in the middle of the dash of 'A': silent abort, no done.
        applyStimulus(0, 5'b00001, 3'd2, 2'd0, 10, 30);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        waitDrain(0);

`ifdef MORSE_SPEED_EN
        // Speed 2 on an 8-cycle unit; speed dropped to 0 mid-letter.
        applyStimulus(2, 5'b00001, 3'd2, 2'd2, -1, 3);
        repeat (2) @(posedge clk);
        #1;
        bus8.speed = 2'd0;
        waitDrain(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
Name: morse_sequencer

Overview:
- Downstream playback stage for the 5-bit Morse letter fields that the processor produces on the board.
- Takes one letter (element bits plus length) on a start strobe and plays it as timed dot/dash tones.
- Drives audio_enable, short and long to the audio codec path and the board LEDs.
- Reports busy while playing and pulses done on completion, so software or the top level can stream letters back-to-back.

Parameters:
- UNIT_CYCLES, 4, clk cycles per Morse time unit (legal range 1 to 2^20).
- MAX_LEN, 5, maximum number of elements per letter; equals the pattern width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to play a letter; sampled only in IDLE
- pattern  in  5  element bits; 1 = dash, 0 = dot; played MSB-first from pattern[len-1] down to pattern[0]
- len  in  3  element count, 0..5; values 6 and 7 are clamped to 5
- audio_enable  out  1  tone on
- short  out  1  high during a dot tone
- long  out  1  high during a dash tone
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous and active-high. On the next edge, state goes to IDLE; all counters clear; audio_enable, short, long, busy and done are 0. Reset mid-letter aborts playback silently, with no done pulse.
- Timing units: dot tone = 1U, dash tone = 3U, inter-element gap = 1U, trailing letter gap = 3U, where U = UNIT_CYCLES.
- States and transitions:
  - IDLE -> TONE, or -> LGAP when len == 0.
  - TONE -> GAP, or -> LGAP after the last element.
  - GAP -> TONE.
  - LGAP -> IDLE.
- Acceptance: start in IDLE at edge t latches pattern, clamped len and element index = len-1.
  - At t+1 the state is TONE, and audio_enable plus short or long are high.
  - Outputs are registered (Moore), so there is no combinational path from start to the outputs.
- TONE: lasts exactly 1U or 3U cycles. short = ~pattern_q[idx] and long = pattern_q[idx]; exactly one of them is high, and never both.
- GAP: U cycles with all tone outputs 0; then idx decrements and the state returns to TONE.
- Last element: the tone is followed directly by LGAP (3U silent cycles). The 1U inter-element gap is not also inserted.
- len == 0: no tone; 3U cycles of LGAP, then done.
- Completion: on the cycle the state re-enters IDLE, done = 1 and busy = 0. A start in that same cycle is accepted, which gives gapless streaming.
- start while busy: ignored; it is neither queued nor allowed to corrupt the latched pattern.
- pattern and len are don't-care except in the accept cycle.
- Counters:
  - Unit prescaler counts 0..U-1.
  - Duration counter counts units, 0..2.
  - Both clear on every state change.
  - Widths come from $clog2 of the parameters; there is no wrap-around inside a phase.

Optional Feature:
- Macro: MORSE_SPEED_EN.
- Defined: adds input speed (2 bits). It is latched on start, and the effective unit is UNIT_CYCLES >> speed, with a minimum of 1 cycle. Changing speed mid-letter has no effect.
- Undefined: the port is absent and the unit is always UNIT_CYCLES.

Decomposition:
- Shared package/header morse_pkg holds:
  - the state encoding (IDLE, TONE, GAP, LGAP)
  - the constants DOT_UNITS=1, DASH_UNITS=3, EGAP_UNITS=1, LGAP_UNITS=3
  - MAX_LEN
- One sub-module, morse_tick_gen: a prescaler producing a one-cycle unit_tick every U cycles, with a synchronous clear input and the period as input.

Test Plan:
- Letter 'A' (UNIT_CYCLES=4, pattern=5'b00001, len=2), start at cycle 0:
  - short=1 on cycles 1-4
  - silent on cycles 5-8
  - long=1 on cycles 9-20
  - silent on cycles 21-32
  - done=1 and busy=0 on cycle 33
- len=0, start at cycle 0 -> no audio_enable ever; busy on cycles 1-12; done on cycle 13.
- len=7, pattern=5'b11111, U=1 -> exactly 5 dashes of 3 cycles each with 1-cycle gaps, then a 3-cycle trailing gap; done on cycle 23.
- start re-asserted on cycle 6 of 'A' -> ignored, waveform unchanged. Then start held on the done cycle (33) -> the next letter's tone begins at cycle 34.
- reset asserted on cycle 10 of 'A' (mid-dash) -> at cycle 11 all outputs are 0 and the state is IDLE; no done pulse follows.
- MORSE_SPEED_EN with UNIT_CYCLES=8, speed=2 -> the dot tone lasts 2 cycles; speed changed mid-letter has no effect.
